// File: rtl/approx_mult_pkg.sv
// Shared widths and the response record for the approximate-multiplier arbiter.
package approx_mult_pkg;
    localparam int unsigned OP_W       = 8;
    localparam int unsigned PROD_W     = 16;
    localparam int unsigned ID_MAX_W   = 3;
    // Partial products landing in columns below this are dropped by the approximate core.
    localparam int unsigned TRUNC_COLS = 4;

    typedef struct packed {
        logic [ID_MAX_W-1:0] id;
        logic [PROD_W-1:0]   z;
    } rsp_t;
endpackage

// File: rtl/approx_mult_arbiter_if.sv
// Request/response bundle between accelerator lanes and the shared multiplier.
interface approx_mult_arbiter_if
    import approx_mult_pkg::*;
#(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = 2
) ();
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*OP_W-1:0] req_x;
    logic [N*OP_W-1:0] req_y;
    logic              cfg_exact;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [PROD_W-1:0] rsp_z;
    logic              busy;

    modport master (
        output req_valid, req_x, req_y, cfg_exact, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_z, busy
    );

    modport slave (
        input  req_valid, req_x, req_y, cfg_exact, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_z, busy
    );
endinterface

// File: rtl/approx_mul_core.sv
// Truncated-array approximate multiplier: partial products in the low TRUNC_COLS columns are dropped.
module approx_mul_core
    import approx_mult_pkg::*;
(
    input  logic [OP_W-1:0]   i_x,
    input  logic [OP_W-1:0]   i_y,
    output logic [PROD_W-1:0] o_z
);
    localparam logic [PROD_W-1:0] ROW_MASK = {{(PROD_W-TRUNC_COLS){1'b1}}, {TRUNC_COLS{1'b0}}};

    logic [PROD_W-1:0] w_row;

    always_comb begin
        o_z   = '0;
        w_row = '0;
        for (int unsigned j = 0; j < OP_W; j++) begin
            w_row = i_y[j] ? (PROD_W'(i_x) << j) : '0;
            o_z   = o_z + (w_row & ROW_MASK);
        end
    end
endmodule

// File: rtl/approx_mult_arbiter.sv
// Round-robin share of one 8x8 multiplier: credit-limited grants, 2-stage pipe, show-ahead output FIFO.
module approx_mult_arbiter
    import approx_mult_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned IDW   = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    approx_mult_arbiter_if.slave bus
);
    localparam int unsigned    CW      = $clog2(DEPTH + 1);
    localparam int unsigned    AW      = $clog2(DEPTH);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEPTH);
    localparam logic [IDW-1:0] LAST_ID = IDW'(N - 1);

    logic [CW-1:0]     r_cnt;
    logic [IDW-1:0]    r_ptr;
    logic [N-1:0]      w_grant;
    logic [IDW-1:0]    w_win;
    logic [IDW-1:0]    w_idx;
    logic              w_found;
    logic [OP_W-1:0]   w_x;
    logic [OP_W-1:0]   w_y;

    logic              r_v1;
    logic [OP_W-1:0]   r_x1;
    logic [OP_W-1:0]   r_y1;
    logic [IDW-1:0]    r_id1;
    logic              r_ex1;
    logic              r_v2;
    logic [IDW-1:0]    r_id2;
    logic [PROD_W-1:0] r_z2;
    logic [PROD_W-1:0] w_approx;
    logic [PROD_W-1:0] w_exact;

    rsp_t              r_mem [DEPTH];
    logic [AW-1:0]     r_wr;
    logic [AW-1:0]     r_rd;
    logic [CW-1:0]     r_fcnt;
    rsp_t              w_s2;
    rsp_t              w_head;
    logic              w_fempty;
    logic              w_rvalid;
    logic              w_pop;
    logic              w_push;
    logic              w_fpop;

    // Search starts at r_ptr; grants are withheld once every FIFO slot is promised.
    always_comb begin
        w_grant = '0;
        w_win   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        if (!rst && (r_cnt < CNT_MAX)) begin
            for (int unsigned k = 0; k < N; k++) begin
                w_idx = IDW'((32'(r_ptr) + k) % N);
                if (!w_found && bus.req_valid[w_idx]) begin
                    w_found = 1'b1;
                    w_win   = w_idx;
                end
            end
        end
        if (w_found) w_grant[w_win] = 1'b1;
    end

    assign bus.req_ready = w_grant;
    assign w_x = bus.req_x[w_win*OP_W +: OP_W];
    assign w_y = bus.req_y[w_win*OP_W +: OP_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
            r_v1  <= 1'b0;
            r_x1  <= '0;
            r_y1  <= '0;
            r_id1 <= '0;
            r_ex1 <= 1'b0;
        end else begin
            r_v1 <= w_found;
            if (w_found) begin
                r_ptr <= (w_win == LAST_ID) ? '0 : w_win + 1'b1;
                r_x1  <= w_x;
                r_y1  <= w_y;
                r_id1 <= w_win;
                r_ex1 <= bus.cfg_exact;
            end
        end
    end

    approx_mul_core u_core (
        .i_x (r_x1),
        .i_y (r_y1),
        .o_z (w_approx)
    );

    assign w_exact = PROD_W'(r_x1) * PROD_W'(r_y1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v2  <= 1'b0;
            r_id2 <= '0;
            r_z2  <= '0;
        end else begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_id2 <= r_id1;
                r_z2  <= r_ex1 ? w_exact : w_approx;
            end
        end
    end

    // With the FIFO empty, S2 is presented directly; it is only stored if not taken this cycle.
    assign w_s2     = {ID_MAX_W'(r_id2), r_z2};
    assign w_fempty = (r_fcnt == '0);
    assign w_head   = w_fempty ? w_s2 : r_mem[r_rd];
    assign w_rvalid = !w_fempty || r_v2;
    assign w_pop    = w_rvalid && bus.rsp_ready;
    assign w_push   = r_v2 && !(w_fempty && w_pop);
    assign w_fpop   = w_pop && !w_fempty;

    assign bus.rsp_valid = w_rvalid;
    assign bus.rsp_id    = IDW'(w_head.id);
    assign bus.rsp_z     = w_head.z;
    assign bus.busy      = (r_cnt != '0);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= w_s2;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr   <= '0;
            r_rd   <= '0;
            r_fcnt <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_fpop) r_rd <= r_rd + 1'b1;
            r_fcnt <= r_fcnt + CW'(w_push) - CW'(w_fpop);
            r_cnt  <= r_cnt + CW'(w_found) - CW'(w_pop);
        end
    end
endmodule
